// File: rtl/apb2axi_cmd_sched_if.sv
// Bus bundle for the APB-to-AXI command scheduler: command capture from the
// register gateway, AXI AW/AR address channels, completion pulses and status.
//
// Handshake rule for AW and AR: a transfer happens on a rising clock edge where
// both valid and ready are high. Once valid is raised, it and the payload
// (addr/len/size/burst/id) stay unchanged until that edge. Valid never depends
// combinationally on ready.
interface apb2axi_cmd_sched_if #(
  parameter int AXI_ADDR_W = 64,
  parameter int ID_W       = 4,
  parameter int CNT_W      = 4
);
  // command capture from the gateway
  logic                  commit_pulse;
  logic [AXI_ADDR_W-1:0] cmd_addr;
  logic [7:0]            cmd_len;
  logic [2:0]            cmd_size;
  logic                  cmd_is_write;
  logic                  cmd_drop;
  // AXI write address channel
  logic                  awvalid;
  logic                  awready;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic [ID_W-1:0]       awid;
  // AXI read address channel
  logic                  arvalid;
  logic                  arready;
  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic [ID_W-1:0]       arid;
  // completions and status
  logic                  wr_done;
  logic                  rd_done;
  logic [CNT_W-1:0]      outst_cnt;
  logic                  cnt_err;
  logic                  idle;
  // scheduler FSM state for observation (0=IDLE, 1=ISSUE_AW, 2=ISSUE_AR)
  logic [1:0]            state_dbg;

  // scheduler side: AXI address master
  modport master (
    input  commit_pulse, cmd_addr, cmd_len, cmd_size, cmd_is_write,
    input  awready, arready, wr_done, rd_done,
    output cmd_drop,
    output awvalid, awaddr, awlen, awsize, awburst, awid,
    output arvalid, araddr, arlen, arsize, arburst, arid,
    output outst_cnt, cnt_err, idle, state_dbg
  );

  // gateway / interconnect side
  modport slave (
    output commit_pulse, cmd_addr, cmd_len, cmd_size, cmd_is_write,
    output awready, arready, wr_done, rd_done,
    input  cmd_drop,
    input  awvalid, awaddr, awlen, awsize, awburst, awid,
    input  arvalid, araddr, arlen, arsize, arburst, arid,
    input  outst_cnt, cnt_err, idle, state_dbg
  );
endinterface

// File: rtl/apb2axi_cmd_sched.sv
// Command scheduler: queues committed commands per direction, arbitrates
// round-robin between write and read queues and issues them on AXI AW/AR,
// throttled by a global outstanding-transaction limit.
module apb2axi_cmd_sched #(
  parameter int AXI_ADDR_W = 64,
  parameter int Q_DEPTH    = 4,
  parameter int MAX_OUTST  = 8,
  parameter int ID_W       = 4
) (
  input logic                  pclk,
  input logic                  presetn,
  apb2axi_cmd_sched_if.master  bus
);

  localparam int PW     = $clog2(Q_DEPTH);
  localparam int CW     = $clog2(MAX_OUTST + 1);
  localparam int EW     = AXI_ADDR_W + 11;  // {addr, len, size}
  localparam int DIR_RD = 0;
  localparam int DIR_WR = 1;

  localparam logic [PW:0]     PTR_ONE = 1;
  localparam logic [ID_W-1:0] ID_ONE  = 1;
  localparam logic [CW-1:0]   MAX_C   = CW'(MAX_OUTST);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ISSUE_AW = 2'd1,
    S_ISSUE_AR = 2'd2
  } state_e;

  state_e state_q, state_d;

  // index 0 holds reads, index 1 holds writes
  logic [EW-1:0] mem_q  [2][Q_DEPTH];
  logic [PW:0]   wptr_q [2];
  logic [PW:0]   rptr_q [2];
  logic [EW-1:0] head   [2];
  logic [1:0]    push, pop, full, empty, accept, drop;

  logic            last_grant_q;  // 1 = last issue was a write
  logic [ID_W-1:0] awid_q, arid_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            cnt_err_q, cnt_err_d;
  logic            cmd_drop_q;
  logic [CW:0]     cnt_up, cnt_dn;
  logic            eligible;

  // queue status, push acceptance (full queue accepts when popped same cycle)
  always_comb begin
    push[DIR_WR] = bus.commit_pulse & bus.cmd_is_write;
    push[DIR_RD] = bus.commit_pulse & ~bus.cmd_is_write;
    pop[DIR_WR]  = (state_q == S_ISSUE_AW) & bus.awready;
    pop[DIR_RD]  = (state_q == S_ISSUE_AR) & bus.arready;
    for (int d = 0; d < 2; d++) begin
      empty[d]  = (wptr_q[d] == rptr_q[d]);
      full[d]   = (wptr_q[d][PW] != rptr_q[d][PW]) &&
                  (wptr_q[d][PW-1:0] == rptr_q[d][PW-1:0]);
      accept[d] = push[d] & (~full[d] | pop[d]);
      drop[d]   = push[d] & full[d] & ~pop[d];
      head[d]   = mem_q[d][rptr_q[d][PW-1:0]];
    end
  end

  // queue storage, written on accepted push
  always_ff @(posedge pclk) begin
    for (int d = 0; d < 2; d++) begin
      if (accept[d]) begin
        mem_q[d][wptr_q[d][PW-1:0]] <= {bus.cmd_addr, bus.cmd_len, bus.cmd_size};
      end
    end
  end

  // queue pointers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int d = 0; d < 2; d++) begin
        wptr_q[d] <= '0;
        rptr_q[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (accept[d]) wptr_q[d] <= wptr_q[d] + PTR_ONE;
        if (pop[d])    rptr_q[d] <= rptr_q[d] + PTR_ONE;
      end
    end
  end

  // arbitration: opposite of last grant on a tie, throttled by outstanding limit
  always_comb begin
    state_d  = state_q;
    eligible = (cnt_q < MAX_C);
    case (state_q)
      S_IDLE: begin
        if (eligible) begin
          if (!empty[DIR_WR] && !empty[DIR_RD]) begin
            state_d = last_grant_q ? S_ISSUE_AR : S_ISSUE_AW;
          end else if (!empty[DIR_WR]) begin
            state_d = S_ISSUE_AW;
          end else if (!empty[DIR_RD]) begin
            state_d = S_ISSUE_AR;
          end
        end
      end
      S_ISSUE_AW: if (bus.awready) state_d = S_IDLE;
      S_ISSUE_AR: if (bus.arready) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // outstanding count: +1 per issue, -1 per done, clamp at zero and flag underflow
  always_comb begin
    cnt_up = {1'b0, cnt_q} + {{CW{1'b0}}, (pop[DIR_WR] | pop[DIR_RD])};
    cnt_dn = {{CW{1'b0}}, bus.wr_done} + {{CW{1'b0}}, bus.rd_done};
    if (cnt_up < cnt_dn) begin
      cnt_d     = '0;
      cnt_err_d = 1'b1;
    end else begin
      cnt_d     = CW'(cnt_up - cnt_dn);
      cnt_err_d = 1'b0;
    end
  end

  // FSM state, grant history, ID counters, counter and pulse registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b0;
      awid_q       <= '0;
      arid_q       <= '0;
      cnt_q        <= '0;
      cnt_err_q    <= 1'b0;
      cmd_drop_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cnt_err_q  <= cnt_err_d;
      cmd_drop_q <= |drop;
      if (pop[DIR_WR]) begin
        last_grant_q <= 1'b1;
        awid_q       <= awid_q + ID_ONE;
      end else if (pop[DIR_RD]) begin
        last_grant_q <= 1'b0;
        arid_q       <= arid_q + ID_ONE;
      end
    end
  end

  // channel outputs: payload is the queue head while valid, zero otherwise
  always_comb begin
    bus.awvalid   = (state_q == S_ISSUE_AW);
    bus.arvalid   = (state_q == S_ISSUE_AR);
    bus.awburst   = 2'b01;
    bus.arburst   = 2'b01;
    bus.awaddr    = '0;
    bus.awlen     = '0;
    bus.awsize    = '0;
    bus.awid      = '0;
    bus.araddr    = '0;
    bus.arlen     = '0;
    bus.arsize    = '0;
    bus.arid      = '0;
    if (bus.awvalid) begin
      {bus.awaddr, bus.awlen, bus.awsize} = head[DIR_WR];
      bus.awid = awid_q;
    end
    if (bus.arvalid) begin
      {bus.araddr, bus.arlen, bus.arsize} = head[DIR_RD];
      bus.arid = arid_q;
    end
    bus.cmd_drop  = cmd_drop_q;
    bus.cnt_err   = cnt_err_q;
    bus.outst_cnt = cnt_q;
    bus.idle      = (&empty) && (state_q == S_IDLE) && (cnt_q == '0);
    bus.state_dbg = state_q;
  end

endmodule

// File: tb/tb_apb2axi_cmd_sched.sv
// Directed bench for apb2axi_cmd_sched: issue latency, round-robin order,
// stall stability, queue overflow, throttling, counter underflow, async reset.
module tb_apb2axi_cmd_sched;

  localparam int AW = 64;
  localparam int IW = 4;
  localparam int CW = 4;
  localparam int RW = 1 + IW + AW;  // {is_write, id, addr}

  logic pclk;
  logic presetn;
  int   total;
  int   bad;

  logic [RW-1:0] hs_q  [$];
  logic [RW-1:0] exp_q [$];

  apb2axi_cmd_sched_if #(.AXI_ADDR_W(AW), .ID_W(IW), .CNT_W(CW)) bus ();

  apb2axi_cmd_sched #(
    .AXI_ADDR_W(AW), .Q_DEPTH(4), .MAX_OUTST(8), .ID_W(IW)
  ) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  // clock / reset
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // handshake logger: records every AW/AR transfer in issue order
  always @(posedge pclk) begin
    if (presetn) begin
      if (bus.awvalid && bus.awready) hs_q.push_back({1'b1, bus.awid, bus.awaddr});
      if (bus.arvalid && bus.arready) hs_q.push_back({1'b0, bus.arid, bus.araddr});
    end
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic do_reset();
    presetn          = 1'b0;
    bus.commit_pulse = 1'b0;
    bus.cmd_addr     = '0;
    bus.cmd_len      = '0;
    bus.cmd_size     = '0;
    bus.cmd_is_write = 1'b0;
    bus.awready      = 1'b0;
    bus.arready      = 1'b0;
    bus.wr_done      = 1'b0;
    bus.rd_done      = 1'b0;
    step();
    step();
    presetn = 1'b1;
    step();
    hs_q.delete();
    exp_q.delete();
  endtask

  task automatic commit(input logic w, input logic [AW-1:0] a,
                        input logic [7:0] l, input logic [2:0] s);
    bus.commit_pulse = 1'b1;
    bus.cmd_is_write = w;
    bus.cmd_addr     = a;
    bus.cmd_len      = l;
    bus.cmd_size     = s;
    step();
    bus.commit_pulse = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.awvalid !== 1'b0 || bus.arvalid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got aw=%0b ar=%0b exp=0/0", bus.awvalid, bus.arvalid); end
    total++; if (bus.outst_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_outst got=%0d exp=0", bus.outst_cnt); end
    total++; if (bus.idle !== 1'b1) begin
      bad++; $display("FAIL reset_idle got=%0b exp=1", bus.idle); end
    total++; if (bus.cmd_drop !== 1'b0 || bus.cnt_err !== 1'b0) begin
      bad++; $display("FAIL reset_pulses got drop=%0b err=%0b exp=0/0", bus.cmd_drop, bus.cnt_err); end
    total++; if (bus.awaddr !== 64'd0 || bus.araddr !== 64'd0 || bus.awid !== 4'd0) begin
      bad++; $display("FAIL reset_payload got awaddr=%h araddr=%h awid=%0d exp=0", bus.awaddr, bus.araddr, bus.awid); end
    total++; if (bus.state_dbg !== 2'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", bus.state_dbg); end
  endtask

  task automatic test_single_write();
    do_reset();
    commit(1'b1, 64'h0000_0001_0000_1000, 8'd3, 3'd2);
    total++; if (bus.awvalid !== 1'b0) begin
      bad++; $display("FAIL single_early_valid got=%0b exp=0", bus.awvalid); end
    step();
    total++; if (bus.awvalid !== 1'b1 || bus.arvalid !== 1'b0) begin
      bad++; $display("FAIL single_valid got aw=%0b ar=%0b exp=1/0", bus.awvalid, bus.arvalid); end
    total++; if (bus.awaddr !== 64'h0000_0001_0000_1000 || bus.awlen !== 8'd3 || bus.awsize !== 3'd2) begin
      bad++; $display("FAIL single_payload got addr=%h len=%0d size=%0d exp=100001000/3/2", bus.awaddr, bus.awlen, bus.awsize); end
    total++; if (bus.awid !== 4'd0 || bus.awburst !== 2'b01) begin
      bad++; $display("FAIL single_id_burst got id=%0d burst=%b exp=0/01", bus.awid, bus.awburst); end
    bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    total++; if (bus.awvalid !== 1'b0 || bus.outst_cnt !== 4'd1) begin
      bad++; $display("FAIL single_issue got valid=%0b outst=%0d exp=0/1", bus.awvalid, bus.outst_cnt); end
    total++; if (bus.idle !== 1'b0) begin
      bad++; $display("FAIL single_busy got idle=%0b exp=0", bus.idle); end
    bus.wr_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
    total++; if (bus.outst_cnt !== 4'd0 || bus.idle !== 1'b1) begin
      bad++; $display("FAIL single_done got outst=%0d idle=%0b exp=0/1", bus.outst_cnt, bus.idle); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.awready = 1'b1;
    bus.arready = 1'b1;
    commit(1'b1, 64'h1000, 8'd0, 3'd3);
    commit(1'b0, 64'h2000, 8'd1, 3'd3);
    commit(1'b1, 64'h3000, 8'd2, 3'd3);
    commit(1'b0, 64'h4000, 8'd3, 3'd3);
    exp_q.push_back({1'b1, 4'd0, 64'h1000});
    exp_q.push_back({1'b0, 4'd0, 64'h2000});
    exp_q.push_back({1'b1, 4'd1, 64'h3000});
    exp_q.push_back({1'b0, 4'd1, 64'h4000});
    for (int i = 0; i < 20; i++) begin
      if (hs_q.size() >= 4) break;
      step();
    end
    total++; if (hs_q.size() != 4) begin
      bad++; $display("FAIL b2b_count got=%0d exp=4", hs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < hs_q.size()) begin
        total++; if (hs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, hs_q[i], exp_q[i]); end
      end
    end
    step();
    total++; if (bus.outst_cnt !== 4'd4) begin
      bad++; $display("FAIL b2b_outst got=%0d exp=4", bus.outst_cnt); end
    bus.awready = 1'b0;
    bus.arready = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    commit(1'b1, 64'hDEAD_0000_0000_BEE0, 8'd7, 3'd1);
    step();
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.awvalid !== 1'b1 || bus.awaddr !== 64'hDEAD_0000_0000_BEE0 ||
                   bus.awlen !== 8'd7 || bus.awsize !== 3'd1 || bus.awid !== 4'd0) begin
        bad++; $display("FAIL stall_hold[%0d] got valid=%0b addr=%h len=%0d size=%0d id=%0d",
                        i, bus.awvalid, bus.awaddr, bus.awlen, bus.awsize, bus.awid); end
      step();
    end
    total++; if (hs_q.size() != 0) begin
      bad++; $display("FAIL stall_no_hs got=%0d exp=0", hs_q.size()); end
    bus.awready = 1'b1;
    step();
    bus.awready = 1'b0;
    total++; if (hs_q.size() != 1 || bus.awvalid !== 1'b0) begin
      bad++; $display("FAIL stall_release got hs=%0d valid=%0b exp=1/0", hs_q.size(), bus.awvalid); end
  endtask

  task automatic test_full_drop();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      commit(1'b1, 64'h100 * (i + 1), 8'(i), 3'd2);
      if (i < 4) begin
        total++; if (bus.cmd_drop !== 1'b0) begin
          bad++; $display("FAIL full_nodrop[%0d] got=%0b exp=0", i, bus.cmd_drop); end
      end else begin
        total++; if (bus.cmd_drop !== 1'b1) begin
          bad++; $display("FAIL full_drop got=%0b exp=1", bus.cmd_drop); end
      end
    end
    step();
    total++; if (bus.cmd_drop !== 1'b0) begin
      bad++; $display("FAIL full_drop_width got=%0b exp=0", bus.cmd_drop); end
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 4'(i), 64'h100 * (i + 1)});
    bus.awready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    bus.awready = 1'b0;
    total++; if (hs_q.size() != 4) begin
      bad++; $display("FAIL full_hs_count got=%0d exp=4", hs_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < hs_q.size()) begin
        total++; if (hs_q[i] !== exp_q[i]) begin
          bad++; $display("FAIL full_hs[%0d] got=%h exp=%h", i, hs_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_throttle();
    do_reset();
    bus.arready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      commit(1'b0, 64'h8000 + 64'h40 * i, 8'd0, 3'd2);
      step();
    end
    for (int i = 0; i < 6; i++) step();
    total++; if (hs_q.size() != 8 || bus.arvalid !== 1'b0 || bus.outst_cnt !== 4'd8) begin
      bad++; $display("FAIL thr_limit got hs=%0d valid=%0b outst=%0d exp=8/0/8",
                      hs_q.size(), bus.arvalid, bus.outst_cnt); end
    total++; if (bus.idle !== 1'b0) begin
      bad++; $display("FAIL thr_idle got=%0b exp=0", bus.idle); end
    bus.rd_done = 1'b1;
    step();
    bus.rd_done = 1'b0;
    total++; if (bus.outst_cnt !== 4'd7 || bus.arvalid !== 1'b0) begin
      bad++; $display("FAIL thr_done got outst=%0d valid=%0b exp=7/0", bus.outst_cnt, bus.arvalid); end
    step();
    total++; if (bus.arvalid !== 1'b1 || bus.araddr !== 64'h8200 || bus.arid !== 4'd8) begin
      bad++; $display("FAIL thr_resume got valid=%0b addr=%h id=%0d exp=1/8200/8", bus.arvalid, bus.araddr, bus.arid); end
    bus.rd_done = 1'b1;
    step();
    bus.rd_done = 1'b0;
    total++; if (bus.outst_cnt !== 4'd7 || hs_q.size() != 9) begin
      bad++; $display("FAIL thr_issue_and_done got outst=%0d hs=%0d exp=7/9", bus.outst_cnt, hs_q.size()); end
    bus.wr_done = 1'b1;
    bus.rd_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
    bus.rd_done = 1'b0;
    total++; if (bus.outst_cnt !== 4'd5 || bus.cnt_err !== 1'b0) begin
      bad++; $display("FAIL thr_double_done got outst=%0d err=%0b exp=5/0", bus.outst_cnt, bus.cnt_err); end
    bus.arready = 1'b0;
  endtask

  task automatic test_underflow();
    do_reset();
    bus.wr_done = 1'b1;
    step();
    bus.wr_done = 1'b0;
    total++; if (bus.cnt_err !== 1'b1 || bus.outst_cnt !== 4'd0) begin
      bad++; $display("FAIL uflow_err got err=%0b outst=%0d exp=1/0", bus.cnt_err, bus.outst_cnt); end
    step();
    total++; if (bus.cnt_err !== 1'b0) begin
      bad++; $display("FAIL uflow_pulse got=%0b exp=0", bus.cnt_err); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.arready = 1'b1;
    commit(1'b0, 64'hA0, 8'd0, 3'd0);
    step();
    step();
    bus.arready = 1'b0;
    commit(1'b0, 64'hB0, 8'd0, 3'd0);
    step();
    total++; if (bus.arvalid !== 1'b1 || bus.outst_cnt !== 4'd1) begin
      bad++; $display("FAIL rmid_pre got valid=%0b outst=%0d exp=1/1", bus.arvalid, bus.outst_cnt); end
    #2;
    presetn = 1'b0;
    #1;
    total++; if (bus.arvalid !== 1'b0 || bus.outst_cnt !== 4'd0 || bus.idle !== 1'b1) begin
      bad++; $display("FAIL rmid_async got valid=%0b outst=%0d idle=%0b exp=0/0/1",
                      bus.arvalid, bus.outst_cnt, bus.idle); end
    step();
    presetn = 1'b1;
    step();
    step();
    total++; if (bus.arvalid !== 1'b0 || bus.idle !== 1'b1) begin
      bad++; $display("FAIL rmid_lost got valid=%0b idle=%0b exp=0/1", bus.arvalid, bus.idle); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stall();
    test_full_drop();
    test_throttle();
    test_underflow();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb2axi_cmd_sched.md
Name: apb2axi_cmd_sched

Overview:
- Sits between the APB gateway register block and the AXI master address channels.
- Captures each committed command (commit_pulse plus addr/len/size/is_write) into a per-direction queue.
- Arbitrates round-robin between the write queue and the read queue, and drives the AXI AW or AR channel with a valid/ready handshake.
- Throttles issue against a global outstanding-transaction limit that is decremented by write/read completion pulses.

Parameters:
- AXI_ADDR_W, 64, AXI address width.
- Q_DEPTH, 4, entries per direction queue (power of 2, ≥2).
- MAX_OUTST, 8, max issued-but-uncompleted transactions (reads + writes).
- ID_W, 4, width of awid/arid.

Ports:
- pclk  in  1  clock.
- presetn  in  1  reset; asynchronous, active-low.
- commit_pulse  in  1  one-cycle command commit from gateway.
- cmd_addr  in  AXI_ADDR_W  command address.
- cmd_len  in  8  AXI beat count minus 1.
- cmd_size  in  3  AXI size.
- cmd_is_write  in  1  1=write, 0=read.
- cmd_drop  out  1  one-cycle pulse: command lost because its queue was full.
- awvalid  out  1  AW valid.
- awready  in  1  AW ready.
- awaddr  out  AXI_ADDR_W  AW address.
- awlen  out  8  AW length.
- awsize  out  3  AW size.
- awburst  out  2  fixed 2'b01 (INCR).
- awid  out  ID_W  AW ID.
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- araddr  out  AXI_ADDR_W  AR address.
- arlen  out  8  AR length.
- arsize  out  3  AR size.
- arburst  out  2  fixed 2'b01.
- arid  out  ID_W  AR ID.
- wr_done  in  1  pulse per B handshake.
- rd_done  in  1  pulse per R-last handshake.
- outst_cnt  out  $clog2(MAX_OUTST+1)  current outstanding count.
- cnt_err  out  1  pulse: done received while outst_cnt==0.
- idle  out  1  both queues empty, FSM in IDLE, outst_cnt==0.

Behaviour:
- Reset (async assert, sync release): both queues empty, FSM=IDLE, last_grant=READ (so write wins first tie), awid/arid counters=0, outst_cnt=0. All valid/pulse outputs 0; payload outputs 0; idle=1. Reset mid-handshake drops awvalid/arvalid immediately; the in-flight command is lost.
- Push: commit_pulse sampled high → {addr,len,size} written into wr_q if cmd_is_write, else rd_q, at that edge.
- Full queue: if the target queue is full and not popped that same cycle, the command is discarded and cmd_drop pulses the following cycle. Push and pop in the same cycle on a full queue is accepted.
- FSM states: IDLE, ISSUE_AW, ISSUE_AR.
  - IDLE: eligible = outst_cnt < MAX_OUTST.
    - If eligible and both queues are non-empty: go to the direction opposite last_grant.
    - If eligible and only one queue is non-empty: go to that one.
    - Otherwise stay in IDLE.
  - ISSUE_AW: awvalid=1; awaddr/awlen/awsize/awid driven from wr_q head and awid counter, held stable until awready. On awvalid&awready: pop wr_q, awid counter+1 (wraps mod 2^ID_W), outst_cnt+1, last_grant=WRITE, go to IDLE.
  - ISSUE_AR: mirror of ISSUE_AW for the read side.
- awvalid and arvalid are never high together. Valid is never deasserted before ready.
- Latency: commit at edge N → valid high in the cycle following edge N+1, i.e. valid is asserted 2 cycles after the commit is sampled. Minimum spacing between handshakes is 2 cycles (IDLE cycle between issues).
- Outstanding counter:
  - Issue handshake alone: +1.
  - wr_done or rd_done alone: -1.
  - wr_done and rd_done together: -2.
  - Issue plus one done in the same cycle: net unchanged.
  - Issue plus both dones: net -1.
  - Saturates at 0; any done that would underflow pulses cnt_err for one cycle and the count stays at 0.
- Throttle: at outst_cnt==MAX_OUTST the FSM stays in IDLE; a command already in ISSUE_* completes normally.
- No 4KB-boundary or len/size legality checks; fields pass through unchanged.

Test Plan:
- Reset then single write commit (addr=0x0000_0001_0000_1000, len=3, size=2) → awvalid high 2 cycles later with those values, awid=0, awburst=01. With awready=1: outst_cnt=1, then wr_done → outst_cnt=0, idle=1.
- Two writes and two reads committed back-to-back, awready/arready held 1 → issue order W,R,W,R; awid 0,1 and arid 0,1; outst_cnt=4.
- Hold awready=0 for 5 cycles → awvalid and payload stable for all 5 cycles; handshake only on the cycle awready=1.
- Commit 5 writes with awready=0 and Q_DEPTH=4 → 5th write raises cmd_drop for one cycle; exactly 4 AW handshakes after awready is released.
- Issue 8 reads with no rd_done → 9th read held in queue with arvalid=0. Then rd_done → arvalid asserts. Issue in the same cycle as rd_done → outst_cnt unchanged.
- wr_done with outst_cnt=0 → cnt_err pulse and outst_cnt stays 0. Assert presetn low while arvalid=1 → arvalid=0 immediately, outst_cnt=0, idle=1.
